// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master)
// and instruction memory (slave).
interface fetch_unit_if #(
   parameter int PC_BITS   = 64,
   parameter int INSN_BITS = 32
);
   logic                 out_imem_req_valid;
   logic [PC_BITS-1:0]   out_imem_req_addr;
   logic                 in_imem_req_ready;
   logic                 in_imem_resp_valid;
   logic [INSN_BITS-1:0] in_imem_resp_insnbits;

   modport master (
      output out_imem_req_valid,
      output out_imem_req_addr,
      input  in_imem_req_ready,
      input  in_imem_resp_valid,
      input  in_imem_resp_insnbits
   );

   modport slave (
      input  out_imem_req_valid,
      input  out_imem_req_addr,
      output in_imem_req_ready,
      output in_imem_resp_valid,
      output in_imem_resp_insnbits
   );
endinterface

// File: rtl/fetch_unit.sv
// In-order fetch front end: owns the fetch PC, issues credit-limited imem requests,
// buffers responses with their PCs, delivers one per cycle, and handles redirect/HLT.
module fetch_unit #(
   parameter int                 INSN_BITS  = 32,
   parameter int                 PC_BITS    = 64,
   parameter int                 FIFO_DEPTH = 4,
   parameter logic [PC_BITS-1:0] RESET_PC   = '0
) (
   input  logic                 in_clk,
   input  logic                 in_rst,
   input  logic                 in_stall,
   input  logic                 in_redirect_valid,
   input  logic [PC_BITS-1:0]   in_redirect_pc,
   fetch_unit_if.master         imem,
   output logic [INSN_BITS-1:0] out_fetch_insnbits,
   output logic [PC_BITS-1:0]   out_fetch_pc,
   output logic                 out_fetch_done,
   output logic                 out_halted
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   // Drop count can accumulate across back-to-back redirects, so give it headroom.
   localparam int DW = CW + 3;

   localparam logic [INSN_BITS-1:0] HLT_MASK = INSN_BITS'(32'hFFE0_001F);
   localparam logic [INSN_BITS-1:0] HLT_VAL  = INSN_BITS'(32'hD440_0000);

   logic [PC_BITS-1:0]   pc_q, pc_d;
   logic [CW-1:0]        inflight_q, inflight_d;
   logic [DW-1:0]        drop_q, drop_d;
   logic                 halted_q, halted_d;
   logic [CW-1:0]        count_q, count_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        pcq_rd_q, pcq_rd_d;
   logic [AW-1:0]        pcq_wr_q, pcq_wr_d;
   logic                 done_q, done_d;
   logic [INSN_BITS-1:0] insn_q, insn_d;
   logic [PC_BITS-1:0]   opc_q, opc_d;

   logic [INSN_BITS-1:0] fifo_insn_q [FIFO_DEPTH];
   logic [PC_BITS-1:0]   fifo_pc_q   [FIFO_DEPTH];
   logic [PC_BITS-1:0]   pcq_q       [FIFO_DEPTH];

   logic credit_ok;
   logic req_valid;
   logic req_fire;
   logic resp;
   logic resp_drop;
   logic resp_keep;
   logic push;
   logic pop;
   logic empty;
   logic is_hlt;
   logic unused_redirect_lsb;

   assign unused_redirect_lsb = ^in_redirect_pc[1:0];

   assign credit_ok = ({1'b0, count_q} + {1'b0, inflight_q}) < (CW + 1)'(FIFO_DEPTH);
   assign req_valid = !halted_q && !in_redirect_valid && credit_ok;
   assign req_fire  = req_valid && imem.in_imem_req_ready;

   // Dropped responses belong to requests issued before the last redirect, so they
   // never touch the inflight count or the PC queue.
   assign resp      = imem.in_imem_resp_valid;
   assign resp_drop = resp && (drop_q != '0);
   assign resp_keep = resp && (drop_q == '0);
   assign empty     = (count_q == '0);
   assign push      = resp_keep && !in_redirect_valid;
   assign pop       = !in_stall && !empty && !in_redirect_valid;
   assign is_hlt    = (imem.in_imem_resp_insnbits & HLT_MASK) == HLT_VAL;

   assign imem.out_imem_req_valid = req_valid;
   assign imem.out_imem_req_addr  = pc_q;

   assign out_fetch_insnbits = insn_q;
   assign out_fetch_pc       = opc_q;
   assign out_fetch_done     = done_q;
   assign out_halted         = halted_q;

   always_comb begin
      pc_d       = pc_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      halted_d   = halted_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      pcq_rd_d   = pcq_rd_q;
      pcq_wr_d   = pcq_wr_q;
      done_d     = pop;
      insn_d     = insn_q;
      opc_d      = opc_q;

      if (pop) begin
         insn_d = fifo_insn_q[rd_ptr_q];
         opc_d  = fifo_pc_q[rd_ptr_q];
      end

      if (in_redirect_valid) begin
         pc_d       = {in_redirect_pc[PC_BITS-1:2], 2'b00};
         drop_d     = drop_q + DW'(inflight_q) - DW'(resp);
         inflight_d = '0;
         halted_d   = 1'b0;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         pcq_rd_d   = '0;
         pcq_wr_d   = '0;
      end else begin
         if (req_fire)
            pc_d = pc_q + PC_BITS'(4);
         inflight_d = inflight_q + CW'(req_fire) - CW'(resp_keep);
         drop_d     = drop_q - DW'(resp_drop);
         if (push && is_hlt)
            halted_d = 1'b1;
         count_d  = count_q + CW'(push) - CW'(pop);
         rd_ptr_d = rd_ptr_q + AW'(pop);
         wr_ptr_d = wr_ptr_q + AW'(push);
         pcq_rd_d = pcq_rd_q + AW'(resp_keep);
         pcq_wr_d = pcq_wr_q + AW'(req_fire);
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         pc_q       <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
         halted_q   <= 1'b0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         pcq_rd_q   <= '0;
         pcq_wr_q   <= '0;
         done_q     <= 1'b0;
         insn_q     <= '0;
         opc_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         halted_q   <= halted_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         pcq_rd_q   <= pcq_rd_d;
         pcq_wr_q   <= pcq_wr_d;
         done_q     <= done_d;
         insn_q     <= insn_d;
         opc_q      <= opc_d;
      end
   end

   // Storage arrays carry no reset; validity is tracked entirely by the pointers.
   always_ff @(posedge in_clk) begin
      if (push) begin
         fifo_insn_q[wr_ptr_q] <= imem.in_imem_resp_insnbits;
         fifo_pc_q[wr_ptr_q]   <= pcq_q[pcq_rd_q];
      end
      if (req_fire)
         pcq_q[pcq_wr_q] <= pc_q;
   end

   a_resp_expected: assert property (@(posedge in_clk) disable iff (in_rst)
      !(imem.in_imem_resp_valid && (inflight_q == '0) && (drop_q == '0)));

   a_count_bound: assert property (@(posedge in_clk) disable iff (in_rst)
      count_q <= CW'(FIFO_DEPTH));

endmodule
